// File: rtl/usbf_wb_reg_slave.sv
// Purpose : Wishbone classic responder for the USB function core: register file, sticky event status and buffer RAM.
// Latency : ack (or err) one cycle after stb&cyc, read data registered alongside ack, interrupts registered (+1 cycle).
// Backpr. : never stalls; a held strobe is answered every other cycle (ack is a one-cycle pulse, then one idle cycle).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wb_addr_i/wb_data_i/... Wishbone classic slave; wb_addr_i[AW-1] picks registers (1) or buffer RAM (0)
//   usb_evt_i, ep_evt_i     event pulses latched into INT_SRC[31:24] and the per-endpoint INT status
//   frm_i                   frame number, visible through FRM
//   inta_o, intb_o          level interrupts built from the masked sticky status
//   wb_err_o                only when USBF_WB_ERR_EN is defined: unmapped register accesses answer with err instead of ack
module usbf_wb_reg_slave #(
   parameter int          AW     = 18,
   parameter int          NUM_EP = 2,
   parameter int          MEM_AW = 8,
   parameter logic [31:0] ID_VAL = 32'h0000_0001
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [AW-1:0]       wb_addr_i,
   input  logic [31:0]         wb_data_i,
   output logic [31:0]         wb_data_o,
   input  logic                wb_we_i,
   input  logic                wb_stb_i,
   input  logic                wb_cyc_i,
   output logic                wb_ack_o,
`ifdef USBF_WB_ERR_EN
   output logic                wb_err_o,
`endif
   input  logic [7:0]          usb_evt_i,
   input  logic [6*NUM_EP-1:0] ep_evt_i,
   input  logic [10:0]         frm_i,
   output logic                inta_o,
   output logic                intb_o
);

   // ---------------- address decode ----------------
   logic [AW-3:0]     woff;       // word offset inside the register space
   logic              reg_sel;
   logic              hi_zero;
   logic [1:0]        ep_idx;
   logic [1:0]        ep_reg;
   logic              mapped;
   logic [MEM_AW-1:0] ram_idx;
   logic              unused_addr;

   assign woff        = wb_addr_i[AW-2:2];
   assign reg_sel     = wb_addr_i[AW-1];
   assign hi_zero     = ((woff >> 5) == '0);
   assign ep_idx      = woff[3:2];
   assign ep_reg      = woff[1:0];
   assign ram_idx     = wb_addr_i[MEM_AW+1:2];
   assign unused_addr = ^wb_addr_i[1:0];

   // RAM space is always mapped; register space has 0x00-0x10 and the endpoint window 0x40-0x7F.
   assign mapped = !reg_sel ||
                   (hi_zero && ((!woff[4] && woff[3:0] <= 4'd4) ||
                                ( woff[4] && 32'(ep_idx) < NUM_EP)));

   // ---------------- state ----------------
   logic        ack_q, rd_q, ram_sel_q;
   logic [31:0] reg_q, ram_q;
   logic [6:0]  fa;
   logic [17:0] int_msk;
   logic [7:0]  usb_src;
   logic [31:0] csr    [4];
   logic [31:0] buf0   [4];
   logic [31:0] buf1   [4];
   logic [5:0]  int_en [4];
   logic [5:0]  int_st [4];
   logic [31:0] mem [0:(2**MEM_AW)-1];

   // ---------------- handshake ----------------
   logic req, ack_d, wr, rd, clr_src, clr_ep;

`ifdef USBF_WB_ERR_EN
   logic err_q, err_d;
   assign req      = wb_stb_i & wb_cyc_i & ~ack_q & ~err_q;
   assign err_d    = req & reg_sel & ~mapped;
   assign wb_err_o = err_q;
`else
   assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
`endif
`ifdef USBF_WB_ERR_EN
   assign ack_d    = req & ~err_d;
`else
   assign ack_d    = req;
`endif

   assign wr      = req &  wb_we_i & reg_sel & mapped;
   assign rd      = req & ~wb_we_i & reg_sel & mapped;
   assign clr_src = rd & !woff[4] & (woff[2:0] == 3'd3);
   assign clr_ep  = rd &  woff[4] & (ep_reg == 2'd1);

   // ---------------- interrupt pending ----------------
   logic [7:0] pend_vec;
   always_comb begin
      pend_vec = '0;
      for (int i = 0; i < NUM_EP; i++)
         pend_vec[i] = |(int_st[i] & int_en[i]);
   end

   // ---------------- register read mux (pre-clear values) ----------------
   logic [31:0] reg_rd;
   always_comb begin
      reg_rd = '0;
      if (!woff[4]) begin
         case (woff[2:0])
            3'd0:    reg_rd = ID_VAL;
            3'd1:    reg_rd = {25'b0, fa};
            3'd2:    reg_rd = {14'b0, int_msk};
            3'd3:    reg_rd = {usb_src, 16'b0, pend_vec};
            3'd4:    reg_rd = {21'b0, frm_i};
            default: reg_rd = '0;
         endcase
      end else begin
         case (ep_reg)
            2'd0:    reg_rd = csr[ep_idx];
            2'd1:    reg_rd = {2'b0, int_en[ep_idx], 18'b0, int_st[ep_idx]};
            2'd2:    reg_rd = buf0[ep_idx];
            default: reg_rd = buf1[ep_idx];
         endcase
      end
      if (!reg_sel || !mapped)
         reg_rd = '0;
   end

   // ---------------- buffer RAM (no reset, contents undefined) ----------------
   always_ff @(posedge clk_i) begin
      if (req && wb_we_i && !reg_sel && !rst_i)
         mem[ram_idx] <= wb_data_i;
      ram_q <= mem[ram_idx];
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q     <= 1'b0;
         rd_q      <= 1'b0;
         ram_sel_q <= 1'b0;
         reg_q     <= '0;
         fa        <= '0;
         int_msk   <= '0;
         usb_src   <= '0;
         inta_o    <= 1'b0;
         intb_o    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            csr[i]    <= '0;
            buf0[i]   <= '0;
            buf1[i]   <= '0;
            int_en[i] <= '0;
            int_st[i] <= '0;
         end
      end else begin
         ack_q     <= ack_d;
         rd_q      <= req & ~wb_we_i;
         ram_sel_q <= ~reg_sel;
         if (req)
            reg_q <= reg_rd;

         inta_o <= |(usb_src & int_msk[7:0])  | (int_msk[16] & |pend_vec);
         intb_o <= |(usb_src & int_msk[15:8]) | (int_msk[17] & |pend_vec);

         // Clear first, then OR in new events: an event on the clearing edge survives.
         usb_src <= (usb_src & ~{8{clr_src}}) | usb_evt_i;
         for (int i = 0; i < NUM_EP; i++)
            int_st[i] <= (int_st[i] & ~{6{clr_ep && (ep_idx == 2'(i))}}) | ep_evt_i[6*i +: 6];

         if (wr) begin
            if (!woff[4]) begin
               if (woff[2:0] == 3'd1) fa      <= wb_data_i[6:0];
               if (woff[2:0] == 3'd2) int_msk <= wb_data_i[17:0];
            end else begin
               case (ep_reg)
                  2'd0:    csr[ep_idx]    <= wb_data_i;
                  2'd1:    int_en[ep_idx] <= wb_data_i[29:24];
                  2'd2:    buf0[ep_idx]   <= wb_data_i;
                  default: buf1[ep_idx]   <= wb_data_i;
               endcase
            end
         end
      end
   end

`ifdef USBF_WB_ERR_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
   end
`endif

   assign wb_ack_o  = ack_q;
   // Read data is only presented during a read ack; writes and idle cycles return 0.
   assign wb_data_o = (ack_q && rd_q) ? (ram_sel_q ? ram_q : reg_q) : 32'h0;

endmodule

// File: tb/tb_usbf_wb_reg_slave.sv
module tb_usbf_wb_reg_slave;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [17:0] wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic [31:0] wb_data_o;
   logic        wb_we_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_ack_o;
   logic        wb_err;
   logic [7:0]  usb_evt_i = '0;
   logic [11:0] ep_evt_i = '0;
   logic [10:0] frm_i = 11'h5A3;
   logic        inta_o, intb_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   usbf_wb_reg_slave #(.AW(18), .NUM_EP(2), .MEM_AW(8), .ID_VAL(32'h0000_0001)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .wb_data_o (wb_data_o),
      .wb_we_i   (wb_we_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (wb_ack_o),
`ifdef USBF_WB_ERR_EN
      .wb_err_o  (wb_err),
`endif
      .usb_evt_i (usb_evt_i),
      .ep_evt_i  (ep_evt_i),
      .frm_i     (frm_i),
      .inta_o    (inta_o),
      .intb_o    (intb_o)
   );
`ifndef USBF_WB_ERR_EN
   assign wb_err = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One Wishbone transfer; returns after the response plus one idle cycle.
   task automatic wb_xfer(input logic we, input logic [17:0] addr, input logic [31:0] dat,
                          output logic [31:0] rdat, output logic acked, output logic erred,
                          output int lat);
      wb_addr_i = addr; wb_data_i = dat; wb_we_i = we;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      acked = 1'b0; erred = 1'b0; rdat = '0; lat = 0;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk_i); #1;
         if (wb_ack_o || wb_err) begin
            acked = wb_ack_o; erred = wb_err; rdat = wb_data_o; lat = n;
            break;
         end
      end
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   typedef struct {
      logic        we;
      logic [17:0] addr;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[23];

   initial begin
      logic [31:0] rd;
      logic        ak, er;
      int          lat;
      logic [5:0]  pat;

      vt[0]  = '{1'b0, 18'h20000, 32'h0,         32'h0000_0001};
      vt[1]  = '{1'b0, 18'h20004, 32'h0,         32'h0000_0000};
      vt[2]  = '{1'b0, 18'h2000C, 32'h0,         32'h0000_0000};
      vt[3]  = '{1'b1, 18'h20048, 32'h2000_0000, 32'h0};
      vt[4]  = '{1'b0, 18'h20048, 32'h0,         32'h2000_0000};
      vt[5]  = '{1'b1, 18'h20004, 32'hFFFF_FFFF, 32'h0};
      vt[6]  = '{1'b0, 18'h20004, 32'h0,         32'h0000_007F};
      vt[7]  = '{1'b1, 18'h20040, 32'hA5A5_5A5A, 32'h0};
      vt[8]  = '{1'b0, 18'h20040, 32'h0,         32'hA5A5_5A5A};
      vt[9]  = '{1'b1, 18'h2005C, 32'h1234_5678, 32'h0};
      vt[10] = '{1'b0, 18'h2005C, 32'h0,         32'h1234_5678};
      vt[11] = '{1'b0, 18'h20010, 32'h0,         32'h0000_05A3};
      vt[12] = '{1'b1, 18'h20008, 32'hFFFF_FFFF, 32'h0};
      vt[13] = '{1'b0, 18'h20008, 32'h0,         32'h0003_FFFF};
      vt[14] = '{1'b1, 18'h20008, 32'h0000_01FF, 32'h0};
      vt[15] = '{1'b0, 18'h20008, 32'h0,         32'h0000_01FF};
      vt[16] = '{1'b1, 18'h00014, 32'hCAFE_BABE, 32'h0};
      vt[17] = '{1'b0, 18'h10014, 32'h0,         32'hCAFE_BABE};
      vt[18] = '{1'b1, 18'h00000, 32'h0BAD_F00D, 32'h0};
      vt[19] = '{1'b0, 18'h00400, 32'h0,         32'h0BAD_F00D};
      vt[20] = '{1'b1, 18'h20044, 32'hFFFF_FFFF, 32'h0};
      vt[21] = '{1'b0, 18'h20044, 32'h0,         32'h3F00_0000};
      vt[22] = '{1'b0, 18'h2004C, 32'h0,         32'h0000_0000};

      // reset
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ack",  {31'b0, wb_ack_o}, 32'h0);
      chk("rst_data", wb_data_o, 32'h0);
      chk("rst_inta", {31'b0, inta_o}, 32'h0);
      chk("rst_intb", {31'b0, intb_o}, 32'h0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // table
      for (int i = 0; i < 23; i++) begin
         wb_xfer(vt[i].we, vt[i].addr, vt[i].wdat, rd, ak, er, lat);
         chk($sformatf("v%0d_ack", i), {31'b0, ak}, 32'h1);
         chk($sformatf("v%0d_lat", i), lat, 32'd1);
         chk($sformatf("v%0d_data", i), rd, vt[i].exp);
      end

      // USB event -> inta, read-clear of INT_SRC
      usb_evt_i = 8'h12;
      @(posedge clk_i); #1;
      usb_evt_i = 8'h00;
      chk("inta_early", {31'b0, inta_o}, 32'h0);
      @(posedge clk_i); #1;
      chk("inta_set", {31'b0, inta_o}, 32'h1);
      chk("intb_masked", {31'b0, intb_o}, 32'h0);
      wb_xfer(1'b0, 18'h2000C, 32'h0, rd, ak, er, lat);
      chk("int_src_usb", rd, 32'h1200_0000);
      chk("inta_cleared", {31'b0, inta_o}, 32'h0);
      wb_xfer(1'b0, 18'h2000C, 32'h0, rd, ak, er, lat);
      chk("int_src_after_clr", rd, 32'h0);

      // endpoint event colliding with the read-clear edge
      wb_xfer(1'b1, 18'h20044, 32'h3F00_0000, rd, ak, er, lat);
      wb_addr_i = 18'h20044; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      ep_evt_i = 12'h001;
      @(posedge clk_i); #1;
      ep_evt_i = 12'h000;
      chk("coll_ack", {31'b0, wb_ack_o}, 32'h1);
      chk("coll_data", wb_data_o, 32'h3F00_0000);
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk_i); #1;
      wb_xfer(1'b0, 18'h2000C, 32'h0, rd, ak, er, lat);
      chk("ep_pend", rd, 32'h0000_0001);
      chk("inta_ep_masked", {31'b0, inta_o}, 32'h0);
      wb_xfer(1'b1, 18'h20008, 32'h0002_01FF, rd, ak, er, lat);
      chk("intb_ep", {31'b0, intb_o}, 32'h1);
      wb_xfer(1'b0, 18'h20044, 32'h0, rd, ak, er, lat);
      chk("ep_int_sticky", rd, 32'h3F00_0001);
      chk("intb_ep_clr", {31'b0, intb_o}, 32'h0);
      wb_xfer(1'b0, 18'h2000C, 32'h0, rd, ak, er, lat);
      chk("ep_pend_clr", rd, 32'h0);

      // held strobe on a RAM read: acks every other cycle
      wb_addr_i = 18'h00014; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      pat = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk_i); #1;
         pat[c] = wb_ack_o;
         if (wb_ack_o) chk($sformatf("hold_data%0d", c), wb_data_o, 32'hCAFE_BABE);
      end
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk_i); #1;
      chk("hold_pattern", {26'b0, pat}, 32'h0000_0015);

      // unmapped register offsets / endpoint index beyond NUM_EP
      wb_xfer(1'b1, 18'h20060, 32'hDEAD_BEEF, rd, ak, er, lat);
      wb_xfer(1'b0, 18'h20060, 32'h0, rd, ak, er, lat);
`ifdef USBF_WB_ERR_EN
      chk("ep2_err", {30'b0, ak, er}, 32'h1);
`else
      chk("ep2_ack", {30'b0, ak, er}, 32'h2);
`endif
      chk("ep2_data", rd, 32'h0);
      wb_xfer(1'b0, 18'h20030, 32'h0, rd, ak, er, lat);
`ifdef USBF_WB_ERR_EN
      chk("unmap_err", {30'b0, ak, er}, 32'h1);
`else
      chk("unmap_ack", {30'b0, ak, er}, 32'h2);
`endif
      chk("unmap_lat", lat, 32'd1);
      chk("unmap_data", rd, 32'h0);

      // reset during a pending write
      wb_addr_i = 18'h20004; wb_data_i = 32'h0000_0055; wb_we_i = 1'b1;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; rst_i = 1'b1;
      @(posedge clk_i); #1;
      chk("rst_mid_ack", {31'b0, wb_ack_o}, 32'h0);
      rst_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_mid_ack2", {31'b0, wb_ack_o}, 32'h0);
      wb_xfer(1'b0, 18'h20004, 32'h0, rd, ak, er, lat);
      chk("rst_mid_fa_ack", {31'b0, ak}, 32'h1);
      chk("rst_mid_fa", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
